// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial sequence generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// W-bit parallel-load, shift-left register; the MSB is the serial output bit.
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_data,
  output logic         msb
);

  logic [W-1:0] q;

  // Load wins over shift; zeros enter from the bottom so an emptied register idles at 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a W-bit word MSB-first, repeated N times
// with an optional idle gap between repetitions, then pulses done.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int W          = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     data_in,
  input  logic [CNT_W-1:0] repeat_count,
  output logic             ready,
  output logic             busy,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int BW = cnt_width(W);
  localparam int GW = cnt_width(GAP_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [W-1:0]     pattern_q, pattern_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_left_q, rep_left_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             sr_load, sr_shift;
  logic [W-1:0]     sr_data;
  logic             sr_msb;

  // The shift register doubles as the out flop; loading zeros on leaving SHIFT keeps out=0 when invalid.
  seq_shift_reg #(.W(W)) u_shift (
    .clock     (clock),
    .reset     (reset),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data (sr_data),
    .msb       (sr_msb)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pattern_q   <= '0;
      bit_cnt_q   <= '0;
      rep_left_q  <= '0;
      gap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_left_q  <= rep_left_d;
      gap_cnt_q   <= gap_cnt_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    bit_cnt_d   = bit_cnt_q;
    rep_left_d  = rep_left_q;
    gap_cnt_d   = gap_cnt_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_data     = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pattern_d   = data_in;
          sr_load     = 1'b1;
          sr_data     = data_in;
          rep_left_d  = (repeat_count == '0) ? CNT_W'(1) : repeat_count;
          bit_cnt_d   = BIT_LAST;
          out_valid_d = 1'b1;
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_cnt_q != '0) begin
          sr_shift    = 1'b1;
          bit_cnt_d   = bit_cnt_q - BW'(1);
          out_valid_d = 1'b1;
        end else if (rep_left_q > CNT_W'(1)) begin
          if (GAP_CYCLES > 0) begin
            sr_load   = 1'b1;
            gap_cnt_d = GAP_LAST;
            state_d   = GAP;
          end else begin
            // Reload in the same edge so back-to-back repetitions have no bubble.
            sr_load     = 1'b1;
            sr_data     = pattern_q;
            rep_left_d  = rep_left_q - CNT_W'(1);
            bit_cnt_d   = BIT_LAST;
            out_valid_d = 1'b1;
          end
        end else begin
          sr_load = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end else begin
          sr_load     = 1'b1;
          sr_data     = pattern_q;
          rep_left_d  = rep_left_q - CNT_W'(1);
          bit_cnt_d   = BIT_LAST;
          out_valid_d = 1'b1;
          state_d     = SHIFT;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready     = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign out       = sr_msb;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: one instance back-to-back (GAP=0), one with a 2-cycle gap.
module tb_sequence_generator;

  typedef struct {
    int   cycle;
    logic is_done;
    logic bit_v;
  } item_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [3:0] data0 = '0, data1 = '0;
  logic [3:0] rep0 = '0, rep1 = '0;
  logic       ready0, busy0, out0, out_valid0, done0;
  logic       ready1, busy1, out1, out_valid1, done1;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    det0 = 0, det1 = 0;
  logic [3:0] hist0 = '0, hist1 = '0;
  item_t q0[$];
  item_t q1[$];
  item_t e0, e1;

  sequence_generator #(.W(4), .CNT_W(4), .GAP_CYCLES(0)) u_g0 (
    .clock(clock), .reset(reset), .start(start0), .data_in(data0), .repeat_count(rep0),
    .ready(ready0), .busy(busy0), .out(out0), .out_valid(out_valid0), .done(done0)
  );

  sequence_generator #(.W(4), .CNT_W(4), .GAP_CYCLES(2)) u_g2 (
    .clock(clock), .reset(reset), .start(start1), .data_in(data1), .repeat_count(rep1),
    .ready(ready1), .busy(busy1), .out(out1), .out_valid(out_valid1), .done(done1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkValue(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput(input string name, input item_t e, input int c,
                             input logic o, input logic ov, input logic d);
    checks++;
    if (c != e.cycle || d !== e.is_done || (!e.is_done && (o !== e.bit_v || ov !== 1'b1))) begin
      errors++;
      $display("[TB] FAIL %s: got cycle %0d out=%b valid=%b done=%b, expected cycle %0d out=%b done=%b",
               name, c, o, ov, d, e.cycle, e.bit_v, e.is_done);
    end
  endtask

  // Monitors: every valid bit or done pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!out_valid0) checkValue("g0 out idle zero", out0, 1'b0);
    if (out_valid0 === 1'b1 || done0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL g0 unexpected output: got out=%b valid=%b done=%b, expected nothing (cycle %0d)",
                 out0, out_valid0, done0, cyc);
      end else begin
        e0 = q0.pop_front();
        checkOutput("g0 stream", e0, cyc, out0, out_valid0, done0);
      end
    end
    if (out_valid0) begin
      hist0 = {hist0[2:0], out0};
      if (hist0 == 4'b1011) det0++;
    end else begin
      hist0 = '0;
    end
  end

  always @(negedge clock) begin
    if (!out_valid1) checkValue("g2 out idle zero", out1, 1'b0);
    if (out_valid1 === 1'b1 || done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL g2 unexpected output: got out=%b valid=%b done=%b, expected nothing (cycle %0d)",
                 out1, out_valid1, done1, cyc);
      end else begin
        e1 = q1.pop_front();
        checkOutput("g2 stream", e1, cyc, out1, out_valid1, done1);
      end
    end
    if (out_valid1) begin
      hist1 = {hist1[2:0], out1};
      if (hist1 == 4'b1011) det1++;
    end else begin
      hist1 = '0;
    end
  end

  task automatic pushItem(input int which, input int c, input logic is_done, input logic b);
    item_t it;
    it.cycle = c; it.is_done = is_done; it.bit_v = b;
    if (which == 0) q0.push_back(it); else q1.push_back(it);
  endtask

  // Expected frame: bit i of repetition r after edge k + r*(4+gap) + i, done after the last bit.
  task automatic pushFrame(input int which, input int k, input logic [3:0] bits,
                           input int reps, input int gap);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < 4; i++)
        pushItem(which, k + r * (4 + gap) + i, 1'b0, bits[3 - i]);
    pushItem(which, k + reps * 4 + (reps - 1) * gap, 1'b1, 1'b0);
  endtask

  task automatic applyStimulus(input int which, input logic [3:0] d, input logic [3:0] r,
                               output int k);
    @(negedge clock);
    if (which == 0) begin start0 = 1'b1; data0 = d; rep0 = r; end
    else            begin start1 = 1'b1; data1 = d; rep1 = r; end
    @(posedge clock);
    #1;
    k = cyc;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    do @(negedge clock); while (cyc < c);
  endtask

  task automatic waitDrain(input int which, input string name);
    int n;
    for (int i = 0; i < 60; i++) begin
      n = (which == 0) ? q0.size() : q1.size();
      if (n == 0) break;
      @(negedge clock);
    end
    n = (which == 0) ? q0.size() : q1.size();
    checks++;
    if (n != 0) begin
      errors++;
      $display("[TB] FAIL %s drain: got %0d outputs still pending, expected 0", name, n);
      if (which == 0) q0.delete(); else q1.delete();
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;

    repeat (3) @(negedge clock);
    checkValue("ready in reset", ready0, 1'b0);
    reset = 1'b0;
    #1;
    checkValue("ready after reset", ready0, 1'b1);
    checkValue("busy after reset", busy0, 1'b0);
    checkValue("out_valid after reset", out_valid0, 1'b0);
    checkValue("done after reset", done0, 1'b0);

    // Single 1011 frame with handshake timing.
    applyStimulus(0, 4'b1011, 4'd1, k);
    pushFrame(0, k, 4'b1011, 1, 0);
    checkValue("ready while shifting", ready0, 1'b0);
    waitUntil(k + 4);
    checkValue("busy in done", busy0, 1'b1);
    checkValue("ready in done", ready0, 1'b0);
    waitUntil(k + 5);
    checkValue("ready after done", ready0, 1'b1);
    checkValue("busy after done", busy0, 1'b0);
    waitDrain(0, "single frame");

    // Two repetitions of 1101 separated by a 2-cycle gap.
    applyStimulus(1, 4'b1101, 4'd2, k);
    pushFrame(1, k, 4'b1101, 2, 2);
    waitUntil(k + 5);
    checkValue("g2 busy in gap", busy1, 1'b1);
    waitDrain(1, "gap frame");
    waitUntil(k + 11);
    checkValue("g2 ready after done", ready1, 1'b1);

    // repeat_count 0 behaves as 1.
    applyStimulus(0, 4'b1011, 4'd0, k);
    pushFrame(0, k, 4'b1011, 1, 0);
    waitDrain(0, "repeat zero");

    // Three contiguous repetitions; the detector must fire once per repetition.
    repeat (2) @(negedge clock);
    det0 = 0;
    applyStimulus(0, 4'b1011, 4'd3, k);
    pushFrame(0, k, 4'b1011, 3, 0);
    waitDrain(0, "three reps");
    repeat (3) @(negedge clock);
    checks++;
    if (det0 != 3) begin
      errors++;
      $display("[TB] FAIL loopback g0: got %0d detections, expected 3", det0);
    end

    // Start and input changes during a frame are ignored.
    applyStimulus(0, 4'b1011, 4'd1, k);
    pushFrame(0, k, 4'b1011, 1, 0);
    data0 = 4'b0000;
    rep0  = 4'd5;
    waitUntil(k + 1);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    waitDrain(0, "start while busy");
    repeat (8) @(negedge clock);

    // Start held high: a new frame every time ready returns.
    @(negedge clock);
    start0 = 1'b1; data0 = 4'b1011; rep0 = 4'd1;
    @(posedge clock);
    #1;
    k = cyc;
    pushFrame(0, k, 4'b1011, 1, 0);
    pushFrame(0, k + 6, 4'b1011, 1, 0);
    waitUntil(k + 6);
    start0 = 1'b0;
    waitDrain(0, "held start");

    // Reset after the second bit aborts the frame without a done pulse.
    repeat (2) @(negedge clock);
    applyStimulus(0, 4'b1011, 4'd1, k);
    pushItem(0, k, 1'b0, 1'b1);
    pushItem(0, k + 1, 1'b0, 1'b0);
    waitUntil(k + 1);
    reset = 1'b1;
    @(negedge clock);
    checkValue("out after abort", out0, 1'b0);
    checkValue("out_valid after abort", out_valid0, 1'b0);
    checkValue("done after abort", done0, 1'b0);
    checkValue("busy after abort", busy0, 1'b0);
    reset = 1'b0;
    #1;
    checkValue("ready after abort", ready0, 1'b1);
    repeat (6) @(negedge clock);
    waitDrain(0, "abort");
    applyStimulus(0, 4'b1101, 4'd1, k);
    pushFrame(0, k, 4'b1101, 1, 0);
    waitDrain(0, "after abort");

    // Loopback through the gap instance: detections only on real repetitions.
    repeat (2) @(negedge clock);
    det1 = 0;
    applyStimulus(1, 4'b1011, 4'd2, k);
    pushFrame(1, k, 4'b1011, 2, 2);
    waitDrain(1, "gap loopback");
    repeat (4) @(negedge clock);
    checks++;
    if (det1 != 2) begin
      errors++;
      $display("[TB] FAIL loopback g2: got %0d detections, expected 2", det1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
